fp32_to_int_conv: RTL and testbench

- Multi-cycle converter from IEEE-754 binary32 to a 32-bit signed or unsigned integer.
- It is the reverse path of the FPU add/sub datapath. That datapath packs sign, exponent and mantissa into a float; this block unpacks a float and produces an integer.
- Operands arrive through a valid/ready handshake. The mantissa is aligned by an iterative shifter at SHIFT_STEP bits per cycle.
- The result is held until the consumer accepts it. The block sits beside the FPU unit on the FPU execute path.

---
 rtl/fp32_to_int_conv.sv | 194 +++++++++++++++++++
 tb/tb_fp32_to_int_conv.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/fp32_to_int_conv.sv
`default_nettype none
// ============================================================================
// fp32_to_int_conv : multi-cycle IEEE-754 binary32 -> int32/uint32 converter
// Optional macro FP2INT_RNE_EN selects round-to-nearest-even (default truncate)
// Revision: 1.0
// ============================================================================
module fp32_to_int_conv #(
    parameter int SIZE_DATA  = 32,
    parameter int SHIFT_STEP = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [SIZE_DATA-1:0] i_floating,
    input  logic                 i_signed,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [SIZE_DATA-1:0] o_int_result,
    output logic                 o_flag_invalid,
    output logic                 o_flag_inexact
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        FINISH = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [4:0] STEP_C = 5'(SHIFT_STEP);

    state_t      state, state_next;
    logic        sign, is_signed, shift_left, special, is_nan;
    logic [31:0] work;
    logic        guard, sticky;
    logic [4:0]  cnt;

    // Operand classification, evaluated on the accept cycle
    logic [7:0]  exp_in;
    logic [22:0] frac_in;
    logic [7:0]  exp_diff;
    logic        acc_special, acc_nan, acc_left, acc_sticky;
    logic [4:0]  acc_cnt;
    logic [31:0] acc_work;

    assign exp_in  = i_floating[30:23];
    assign frac_in = i_floating[22:0];

    always_comb begin
        acc_special = (exp_in == 8'hFF) || (exp_in >= 8'd159);
        acc_nan     = (exp_in == 8'hFF) && (frac_in != 23'd0);
        acc_left    = 1'b0;
        acc_sticky  = 1'b0;
        acc_cnt     = 5'd0;
        acc_work    = {8'd0, 1'b1, frac_in};
        exp_diff    = 8'd0;
        if (exp_in == 8'd0) begin
            acc_work   = 32'd0;
            acc_sticky = (frac_in != 23'd0);
        end else if (acc_special) begin
            acc_cnt = 5'd0;
        end else if (exp_in >= 8'd150) begin
            acc_left = 1'b1;
            exp_diff = exp_in - 8'd150;
            acc_cnt  = exp_diff[4:0];
        end else if (exp_in < 8'd124) begin
            acc_cnt = 5'd26;
        end else begin
            exp_diff = 8'd150 - exp_in;
            acc_cnt  = exp_diff[4:0];
        end
    end

    // One shifter step: guard takes the last bit out, sticky the ones before it
    logic [4:0]  amt;
    logic [31:0] lost_mask, guard_mask;
    logic        sh_guard, sh_sticky;

    always_comb begin
        amt        = (cnt < STEP_C) ? cnt : STEP_C;
        lost_mask  = (32'd1 << amt) - 32'd1;
        guard_mask = 32'd1 << (amt - 5'd1);
        sh_guard   = |(work & guard_mask);
        sh_sticky  = sticky | guard | (|(work & lost_mask & ~guard_mask));
    end

    logic [32:0] mag;
    logic [31:0] sat_val, nan_val, fin_result;
    logic        in_range, fin_invalid, fin_inexact;

    always_comb begin
`ifdef FP2INT_RNE_EN
        mag = {1'b0, work} + 33'(guard & (sticky | work[0]));
`else
        mag = {1'b0, work};
`endif
        if (is_signed) begin
            sat_val  = sign ? 32'h8000_0000 : 32'h7FFF_FFFF;
            nan_val  = 32'h7FFF_FFFF;
            in_range = (mag <= 33'h0_7FFF_FFFF) || ((mag == 33'h0_8000_0000) && sign);
        end else begin
            sat_val  = sign ? 32'h0000_0000 : 32'hFFFF_FFFF;
            nan_val  = 32'hFFFF_FFFF;
            in_range = !mag[32] && !(sign && (mag != 33'd0));
        end
        fin_result  = (sign && is_signed) ? (32'd0 - mag[31:0]) : mag[31:0];
        fin_invalid = 1'b0;
        fin_inexact = guard | sticky;
        if (special) begin
            fin_result  = is_nan ? nan_val : sat_val;
            fin_invalid = 1'b1;
            fin_inexact = 1'b0;
        end else if (!in_range) begin
            fin_result  = sat_val;
            fin_invalid = 1'b1;
            fin_inexact = 1'b0;
        end
    end

    assign o_ready = (state == IDLE);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (i_valid) state_next = (acc_cnt != 5'd0) ? SHIFT : FINISH;
            SHIFT:   if (cnt == amt) state_next = FINISH;
            FINISH:  state_next = DONE;
            DONE:    if (i_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sign           <= 1'b0;
            is_signed      <= 1'b0;
            shift_left     <= 1'b0;
            special        <= 1'b0;
            is_nan         <= 1'b0;
            work           <= 32'd0;
            guard          <= 1'b0;
            sticky         <= 1'b0;
            cnt            <= 5'd0;
            o_valid        <= 1'b0;
            o_int_result   <= '0;
            o_flag_invalid <= 1'b0;
            o_flag_inexact <= 1'b0;
        end else begin
            case (state)
                IDLE: if (i_valid) begin
                    sign       <= i_floating[31];
                    is_signed  <= i_signed;
                    shift_left <= acc_left;
                    special    <= acc_special;
                    is_nan     <= acc_nan;
                    work       <= acc_work;
                    guard      <= 1'b0;
                    sticky     <= acc_sticky;
                    cnt        <= acc_cnt;
                end
                SHIFT: begin
                    cnt <= cnt - amt;
                    if (shift_left) begin
                        work <= work << amt;
                    end else begin
                        work   <= work >> amt;
                        guard  <= sh_guard;
                        sticky <= sh_sticky;
                    end
                end
                FINISH: begin
                    o_valid        <= 1'b1;
                    o_int_result   <= fin_result;
                    o_flag_invalid <= fin_invalid;
                    o_flag_inexact <= fin_inexact;
                end
                DONE: if (i_ready) begin
                    o_valid        <= 1'b0;
                    o_flag_invalid <= 1'b0;
                    o_flag_inexact <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fp32_to_int_conv.sv
`default_nettype none
// Table-driven bench for fp32_to_int_conv plus hold/reset sequences.
module tb_fp32_to_int_conv;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic [31:0] i_floating = 32'd0;
    logic        i_signed = 1'b0;
    logic        o_valid;
    logic        i_ready = 1'b0;
    logic [31:0] o_int_result;
    logic        o_flag_invalid;
    logic        o_flag_inexact;

    int checks = 0;
    int errors = 0;

    fp32_to_int_conv #(.SIZE_DATA(32), .SHIFT_STEP(4)) dut (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .i_valid        (i_valid),
        .o_ready        (o_ready),
        .i_floating     (i_floating),
        .i_signed       (i_signed),
        .o_valid        (o_valid),
        .i_ready        (i_ready),
        .o_int_result   (o_int_result),
        .o_flag_invalid (o_flag_invalid),
        .o_flag_inexact (o_flag_inexact)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [31:0] f;
        logic        sg;
        logic [31:0] res;
        logic        inv;
        logic        inx;
        int          lat;
    } vec_t;

    vec_t vecs[$];

`ifdef FP2INT_RNE_EN
    localparam logic [31:0] R_1P5 = 32'd2;
    localparam logic [31:0] R_0P75 = 32'd1;
    localparam logic        INV_M0P75 = 1'b1;
    localparam logic        INX_M0P75 = 1'b0;
`else
    localparam logic [31:0] R_1P5 = 32'd1;
    localparam logic [31:0] R_0P75 = 32'd0;
    localparam logic        INV_M0P75 = 1'b0;
    localparam logic        INX_M0P75 = 1'b1;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Accept one operand and wait for o_valid; lat = edges after accept
    task automatic start_op(input logic [31:0] f, input logic sg, output int lat);
        int w = 0;
        while (!o_ready && w < 100) begin
            @(posedge i_clk); #1; w++;
        end
        i_floating = f;
        i_signed   = sg;
        i_valid    = 1'b1;
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        lat = 0;
        while (!o_valid && lat < 100) begin
            @(posedge i_clk); #1; lat++;
        end
        if (!o_valid) begin
            checks++;
            errors++;
            $display("FAIL timeout: o_valid never rose for %h", f);
        end
    endtask

    task automatic ack(input string name);
        i_ready = 1'b1;
        @(posedge i_clk); #1;
        i_ready = 1'b0;
        chk({name, " valid_after_ack"}, {31'd0, o_valid}, 32'd0);
    endtask

    initial begin
        int lat;
        logic [31:0] held;

        vecs.push_back('{32'h3F800000, 1'b1, 32'h00000001, 1'b0, 1'b0, 7});
        vecs.push_back('{32'hC2F6E979, 1'b1, 32'hFFFFFF85, 1'b0, 1'b1, 6});
        vecs.push_back('{32'h4F000000, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b0, 3});
        vecs.push_back('{32'h4F000000, 1'b0, 32'h80000000, 1'b0, 1'b0, 3});
        vecs.push_back('{32'hCF000000, 1'b1, 32'h80000000, 1'b0, 1'b0, 3});
        vecs.push_back('{32'h7FC00000, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b0, 1});
        vecs.push_back('{32'h7FC00000, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0, 1});
        vecs.push_back('{32'hBF000000, 1'b0, 32'h00000000, 1'b0, 1'b1, 7});
        vecs.push_back('{32'h3FC00000, 1'b1, R_1P5,        1'b0, 1'b1, 7});
        vecs.push_back('{32'h40200000, 1'b1, 32'h00000002, 1'b0, 1'b1, 7});
        vecs.push_back('{32'hFF800000, 1'b1, 32'h80000000, 1'b1, 1'b0, 1});
        vecs.push_back('{32'hFF800000, 1'b0, 32'h00000000, 1'b1, 1'b0, 1});
        vecs.push_back('{32'h00000001, 1'b1, 32'h00000000, 1'b0, 1'b1, 1});
        vecs.push_back('{32'h00000000, 1'b1, 32'h00000000, 1'b0, 1'b0, 1});
        vecs.push_back('{32'h4B000000, 1'b1, 32'h00800000, 1'b0, 1'b0, 1});
        vecs.push_back('{32'h4F800000, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0, 1});
        vecs.push_back('{32'hBF800000, 1'b0, 32'h00000000, 1'b1, 1'b0, 7});
        vecs.push_back('{32'hBF800000, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 7});
        vecs.push_back('{32'h3E800000, 1'b1, 32'h00000000, 1'b0, 1'b1, 8});
        vecs.push_back('{32'h2F800000, 1'b1, 32'h00000000, 1'b0, 1'b1, 8});
        vecs.push_back('{32'h4EFFFFFF, 1'b1, 32'h7FFFFF80, 1'b0, 1'b0, 3});
        vecs.push_back('{32'hCF000001, 1'b1, 32'h80000000, 1'b1, 1'b0, 3});
        vecs.push_back('{32'h4F7FFFFF, 1'b0, 32'hFFFFFF00, 1'b0, 1'b0, 3});
        vecs.push_back('{32'h3F400000, 1'b1, R_0P75,       1'b0, 1'b1, 7});
        vecs.push_back('{32'hBF400000, 1'b0, 32'h00000000, INV_M0P75, INX_M0P75, 7});

        // Reset state
        repeat (3) @(posedge i_clk);
        #1;
        chk("rst o_valid", {31'd0, o_valid}, 32'd0);
        chk("rst o_ready", {31'd0, o_ready}, 32'd1);
        chk("rst result", o_int_result, 32'd0);
        chk("rst flags", {30'd0, o_flag_invalid, o_flag_inexact}, 32'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(posedge i_clk); #1;

        for (int i = 0; i < vecs.size(); i++) begin
            string nm;
            nm = $sformatf("vec%0d(%h,s=%0b)", i, vecs[i].f, vecs[i].sg);
            start_op(vecs[i].f, vecs[i].sg, lat);
            chk({nm, " result"}, o_int_result, vecs[i].res);
            chk({nm, " invalid"}, {31'd0, o_flag_invalid}, {31'd0, vecs[i].inv});
            chk({nm, " inexact"}, {31'd0, o_flag_inexact}, {31'd0, vecs[i].inx});
            chk({nm, " latency"}, lat, vecs[i].lat);
            ack(nm);
        end

        // Result held while the consumer stalls
        start_op(32'hC2F6E979, 1'b1, lat);
        held = o_int_result;
        chk("hold first", held, 32'hFFFFFF85);
        for (int c = 0; c < 5; c++) begin
            @(posedge i_clk); #1;
            chk($sformatf("hold%0d result", c), o_int_result, 32'hFFFFFF85);
            chk($sformatf("hold%0d valid/ready", c), {30'd0, o_valid, o_ready}, 32'd2);
            chk($sformatf("hold%0d inexact", c), {31'd0, o_flag_inexact}, 32'd1);
        end
        ack("hold");
        chk("hold flags cleared", {30'd0, o_flag_invalid, o_flag_inexact}, 32'd0);
        chk("hold ready back", {31'd0, o_ready}, 32'd1);

        // Reset while a result is pending drops o_valid at once
        start_op(32'h7FC00000, 1'b1, lat);
        #2 i_rst_n = 1'b0;
        #1;
        chk("rst_done o_valid", {31'd0, o_valid}, 32'd0);
        chk("rst_done result", o_int_result, 32'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;

        // Reset in the middle of SHIFT aborts the conversion
        @(posedge i_clk); #1;
        i_floating = 32'h3F800000;
        i_signed   = 1'b1;
        i_valid    = 1'b1;
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        @(posedge i_clk); #1;
        chk("shift busy", {31'd0, o_ready}, 32'd0);
        #2 i_rst_n = 1'b0;
        #1;
        chk("rst_shift o_valid", {31'd0, o_valid}, 32'd0);
        chk("rst_shift o_ready", {31'd0, o_ready}, 32'd1);
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(posedge i_clk); #1;
        chk("rst_shift no result", {31'd0, o_valid}, 32'd0);
        chk("rst_shift ready", {31'd0, o_ready}, 32'd1);
        start_op(32'h40200000, 1'b1, lat);
        chk("post_rst result", o_int_result, 32'd2);
        chk("post_rst latency", lat, 7);
        ack("post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
